tlb_plru_gen: RTL
=================

# tlb_plru_gen

Parametrised set-associative TLB with a generalised tree-PLRU for any power-of-two way count and real valid bits. It adds a request/response handshake, duplicate-free insertion and per-PCID invalidation. It sits between the address-generation stage and the page-table walker: lookups return a translated address or a miss, and the walker refills the TLB through the insert port.

## Interface
- SADDR, 64, address width (VA and PA)
- SPAGE, 12, page-offset width
- NSET, 8, number of sets (power of two, ≥2)
- NWAY, 8, ways per set (power of two, ≥2)
- SPCID, 12, process-context identifier width

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, asynchronous and active-high
- req_valid  in  1  lookup request
- req_va  in  SADDR  virtual address for lookup, insert and PCID match
- req_pcid  in  SPCID  PCID for lookup, insert and flush_pcid
- ins_valid  in  1  insert PTE {req_va page, req_pcid} → ins_pa page
- ins_pa  in  SADDR  physical address; only bits [SADDR-1:SPAGE] are used
- flush  in  1  invalidate every entry
- flush_pcid  in  1  invalidate entries whose PCID equals req_pcid
- ready  out  1  block accepts an operation this cycle
- resp_valid  out  1  one-cycle pulse: lookup result valid
- hit  out  1  lookup hit (qualified by resp_valid)
- miss  out  1  lookup miss (qualified by resp_valid)
- ta  out  SADDR  translated address (qualified by resp_valid)

## Operation
- Address split:
  - set = va[SPAGE+log2(NSET)-1:SPAGE]
  - tag = va[SADDR-1:SPAGE+log2(NSET)]
  - offset = va[SPAGE-1:0]
- Entry fields: valid, tag, pcid, ppn (SADDR-SPAGE bits).
- PLRU is NWAY-1 bits per set, organised as a heap: node 0 is the root, and the children of node k are 2k+1 and 2k+2.
  - Bit = 0 means the victim lies in the lower-index half; bit = 1 means the upper half.
  - On a hit or insert, every node on the path to the accessed way is set to point away from it.
- States: IDLE and FLUSHP. ready = (state==IDLE).
- Operation priority in IDLE: flush > flush_pcid > ins_valid > req_valid. Only the highest-priority operation is accepted; lower-priority ones are not accepted, and the source holds them.
- flush:
  - Clears all valid bits and all PLRU bits at the accepting edge.
  - State stays IDLE.
- flush_pcid:
  - Latches req_pcid, enters FLUSHP, set counter = 0.
  - Each FLUSHP cycle clears valid on every way of set[counter] whose pcid matches.
  - Returns to IDLE after set NSET-1 is processed, so ready is low for exactly NSET cycles.
  - PLRU bits are untouched.
- Insert (way selection, in priority order):
  - A valid way with matching tag and pcid is overwritten (no duplicates).
  - Otherwise the lowest-index invalid way.
  - Otherwise the PLRU victim.
  - The written way gets valid=1 and the PLRU is updated toward it.
- Lookup:
  - A hit requires valid && tag match && pcid match. At most one way matches, guaranteed by insert.
  - Hit: ta={ppn, offset}, hit=1, miss=0, and the PLRU is updated.
  - Miss: ta=0, hit=0, miss=1, PLRU unchanged.
- Lookup and insert never stall: ready stays high.
- Array, valid and PLRU contents are all zero out of reset.

## Timing
- Reset (async): state=IDLE, all valid=0, PLRU=0, counter=0, resp_valid=0, hit=0, miss=0, ta=0, ready=1 after release.
- Lookup accepted at edge N:
  - resp_valid/hit/miss/ta are registered and valid during cycle N..N+1, i.e. latency 1.
  - resp_valid, hit and miss are low in all other cycles; ta holds its last value.
- Lookup uses array contents before edge N. An insert accepted at edge N-1 is visible to a lookup at edge N.
- Back-to-back lookups: one response per cycle.
- Reset asserted mid-FLUSHP: the sweep aborts, everything is invalid, and the block is in IDLE after release.
- flush and flush_pcid asserted together: flush wins, and no sweep occurs.

## Test plan
- Reset, then lookup va=0x5123, pcid=1 → resp_valid=1, miss=1, hit=0, ta=0 exactly one cycle after acceptance.
- Insert va=0x5123, pcid=1, pa=0xABCDE000; then lookup the same va/pcid → hit=1, ta=0xABCDE123. Lookup with pcid=2 → miss.
- NWAY=4, NSET=8, pcid=1:
  - Insert tags 1..4 into set 0 (va=tag<<15), then look up tag1 → hit.
  - Insert tag5 → way2 (tag3) is evicted: tag3 lookup misses; tag1, tag2, tag4 and tag5 hit.
- Insert the same va/pcid twice with different pa (0x1000, then 0x2000) → lookup returns ppn 0x2, and no other way of that set becomes valid.
- Fill entries with pcid 1 and 2, assert flush_pcid with pcid=1:
  - ready is low for exactly NSET cycles and req_valid is not accepted meanwhile.
  - Afterwards all pcid1 entries miss and all pcid2 entries hit.
- Assert rst during a FLUSHP sweep → outputs zero immediately (async), ready=1 after release, and all lookups miss. Then assert flush and ins_valid together → flush wins and the insert is not accepted.

Source files
------------

// File: rtl/tlb_plru_gen.sv
// Set-associative TLB with a heap-organised tree-PLRU for any power-of-two way count.
// One lookup or insert per cycle; per-PCID invalidation sweeps one set per cycle.
`timescale 1ns/1ps

module tlb_plru_gen_way #(
  parameter int TAGW  = 49,
  parameter int SPCID = 12
) (
  input  logic             i_valid,
  input  logic [TAGW-1:0]  i_tag,
  input  logic [TAGW-1:0]  i_etag,
  input  logic [SPCID-1:0] i_pcid,
  input  logic [SPCID-1:0] i_epcid,
  input  logic [SPCID-1:0] i_fpcid,
  input  logic [SPCID-1:0] i_fepcid,
  output logic             o_hit,
  output logic             o_fmatch
);
  assign o_hit    = i_valid && (i_tag == i_etag) && (i_pcid == i_epcid);
  assign o_fmatch = (i_fpcid == i_fepcid);
endmodule

module tlb_plru_gen #(
  parameter int SADDR = 64,
  parameter int SPAGE = 12,
  parameter int NSET  = 8,
  parameter int NWAY  = 8,
  parameter int SPCID = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [SADDR-1:0] req_va,
  input  logic [SPCID-1:0] req_pcid,
  input  logic             ins_valid,
  input  logic [SADDR-1:0] ins_pa,
  input  logic             flush,
  input  logic             flush_pcid,
  output logic             ready,
  output logic             resp_valid,
  output logic             hit,
  output logic             miss,
  output logic [SADDR-1:0] ta
);
  localparam int SETW = $clog2(NSET);
  localparam int WAYW = $clog2(NWAY);
  localparam int TAGW = SADDR - SPAGE - SETW;
  localparam int PPNW = SADDR - SPAGE;

  typedef enum logic {S_IDLE, S_FLUSHP} state_t;

  state_t                                  r_state, w_state_nxt;
  logic [SETW-1:0]                         r_cnt, w_cnt_nxt;
  logic [SPCID-1:0]                        r_fpcid;
  logic [NSET-1:0][NWAY-1:0]               r_valid;
  logic [NSET-1:0][NWAY-1:0][TAGW-1:0]     r_tag;
  logic [NSET-1:0][NWAY-1:0][SPCID-1:0]    r_pcid;
  logic [NSET-1:0][NWAY-1:0][PPNW-1:0]     r_ppn;
  logic [NSET-1:0][NWAY-2:0]               r_plru;
  logic                                    r_resp_valid, r_hit, r_miss;
  logic [SADDR-1:0]                        r_ta;

  logic [SETW-1:0]  w_set;
  logic [TAGW-1:0]  w_tag;
  logic [SPAGE-1:0] w_off;
  logic             w_idle, w_do_flush, w_do_fp, w_do_ins, w_do_lkp;
  logic [NWAY-1:0]  w_match, w_fmatch;
  logic             w_hit, w_has_free;
  logic [WAYW-1:0]  w_hit_way, w_free_way, w_victim, w_ins_way, w_touch_way;
  logic [NWAY-2:0]  w_plru_new;
  logic             w_unused;

  // Heap walk: a node bit of 1 sends the victim to the upper half.
  function automatic logic [WAYW-1:0] f_victim(input logic [NWAY-2:0] i_tree);
    logic [NWAY-1:0] t;
    logic [WAYW-1:0] node;
    logic [WAYW-1:0] way;
    t    = {1'b0, i_tree};
    node = '0;
    way  = '0;
    for (int l = 0; l < WAYW; l++) begin
      way[WAYW-1-l] = t[node];
      node = WAYW'(2 * int'(node) + 1 + int'(t[node]));
    end
    return way;
  endfunction

  function automatic logic [NWAY-2:0] f_touch(input logic [NWAY-2:0] i_tree,
                                              input logic [WAYW-1:0] i_way);
    logic [NWAY-1:0] t;
    logic [WAYW-1:0] node;
    logic            b;
    t    = {1'b0, i_tree};
    node = '0;
    for (int l = 0; l < WAYW; l++) begin
      b       = i_way[WAYW-1-l];
      t[node] = ~b;
      node    = WAYW'(2 * int'(node) + 1 + int'(b));
    end
    return t[NWAY-2:0];
  endfunction

  assign w_set = req_va[SPAGE+SETW-1:SPAGE];
  assign w_tag = req_va[SADDR-1:SPAGE+SETW];
  assign w_off = req_va[SPAGE-1:0];
  assign w_unused = ^ins_pa[SPAGE-1:0];

  assign w_idle     = (r_state == S_IDLE);
  assign ready      = w_idle;
  assign w_do_flush = w_idle && flush;
  assign w_do_fp    = w_idle && !flush && flush_pcid;
  assign w_do_ins   = w_idle && !flush && !flush_pcid && ins_valid;
  assign w_do_lkp   = w_idle && !flush && !flush_pcid && !ins_valid && req_valid;

  // Lookup/insert compare against the addressed set; the sweep compares against set r_cnt.
  for (genvar g = 0; g < NWAY; g++) begin : g_way
    tlb_plru_gen_way #(.TAGW(TAGW), .SPCID(SPCID)) u_way (
      .i_valid  (r_valid[w_set][g]),
      .i_tag    (w_tag),
      .i_etag   (r_tag[w_set][g]),
      .i_pcid   (req_pcid),
      .i_epcid  (r_pcid[w_set][g]),
      .i_fpcid  (r_fpcid),
      .i_fepcid (r_pcid[r_cnt][g]),
      .o_hit    (w_match[g]),
      .o_fmatch (w_fmatch[g])
    );
  end

  always_comb begin
    w_hit_way  = '0;
    w_free_way = '0;
    w_has_free = 1'b0;
    for (int w = NWAY - 1; w >= 0; w--) begin
      if (w_match[w]) w_hit_way = WAYW'(w);
      if (!r_valid[w_set][w]) begin
        w_free_way = WAYW'(w);
        w_has_free = 1'b1;
      end
    end
  end

  assign w_hit       = |w_match;
  assign w_victim    = f_victim(r_plru[w_set]);
  assign w_ins_way   = w_hit ? w_hit_way : (w_has_free ? w_free_way : w_victim);
  assign w_touch_way = w_do_ins ? w_ins_way : w_hit_way;
  assign w_plru_new  = f_touch(r_plru[w_set], w_touch_way);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_do_fp) begin
          w_state_nxt = S_FLUSHP;
          w_cnt_nxt   = '0;
        end
      end
      S_FLUSHP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == SETW'(NSET - 1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_fpcid <= '0;
    else if (w_do_fp) r_fpcid <= req_pcid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_valid <= '0;
    else if (w_do_flush)           r_valid <= '0;
    else if (r_state == S_FLUSHP)  r_valid[r_cnt] <= r_valid[r_cnt] & ~w_fmatch;
    else if (w_do_ins)             r_valid[w_set][w_ins_way] <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag  <= '0;
      r_pcid <= '0;
      r_ppn  <= '0;
    end else if (w_do_ins) begin
      r_tag[w_set][w_ins_way]  <= w_tag;
      r_pcid[w_set][w_ins_way] <= req_pcid;
      r_ppn[w_set][w_ins_way]  <= ins_pa[SADDR-1:SPAGE];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_plru <= '0;
    else if (w_do_flush)                    r_plru <= '0;
    else if (w_do_ins || (w_do_lkp && w_hit)) r_plru[w_set] <= w_plru_new;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
      r_ta         <= '0;
    end else begin
      r_resp_valid <= w_do_lkp;
      r_hit        <= w_do_lkp && w_hit;
      r_miss       <= w_do_lkp && !w_hit;
      if (w_do_lkp) r_ta <= w_hit ? {r_ppn[w_set][w_hit_way], w_off} : '0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign hit        = r_hit;
  assign miss       = r_miss;
  assign ta         = r_ta;
endmodule
